// File: rtl/vote_display_ctrl.sv
// Display/mode controller for the voting machine: confirmation flash after each
// accepted vote, live display of a selected candidate's count in result mode,
// and a registered winner/tie/no-votes indication in every mode.
module vote_display_ctrl #(
   parameter int unsigned NUM_CAND     = 4,
   parameter int unsigned CNT_W        = 8,
   parameter int unsigned LED_W        = 8,
   parameter int unsigned FLASH_CYCLES = 10,
   localparam int unsigned IDX_W       = (NUM_CAND > 2) ? $clog2(NUM_CAND) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      mode,
   input  logic                      valid_vote_casted,
   input  logic [NUM_CAND*CNT_W-1:0] votes,
   input  logic [NUM_CAND-1:0]       button_press,
   output logic [LED_W-1:0]          leds,
   output logic                      flash_active,
   output logic [IDX_W-1:0]          winner_idx,
   output logic                      tie,
   output logic                      no_votes
);

   localparam int unsigned CW = $clog2(FLASH_CYCLES + 1);

   typedef enum logic [1:0] {VOTE_IDLE, VOTE_FLASH, RESULT_BLANK, RESULT_SHOW} state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]  sel_q, sel_d;
   logic              sel_vld_q, sel_vld_d;
   logic [LED_W-1:0]  leds_q, leds_d;
   logic              flash_q, flash_d;
   logic [IDX_W-1:0]  winner_q, winner_d;
   logic              tie_q, tie_d;
   logic              nov_q, nov_d;

   logic              btn_any;
   logic [IDX_W-1:0]  btn_idx;
   logic [CNT_W-1:0]  sel_cnt;
   logic [LED_W-1:0]  disp;
   logic [CNT_W-1:0]  max_v;
   int unsigned       n_max;

   // Lowest-index pressed button; descending scan so the lowest index is written last
   always_comb begin
      btn_any = |button_press;
      btn_idx = '0;
      for (int unsigned i = NUM_CAND; i > 0; i--) begin
         if (button_press[i-1]) btn_idx = IDX_W'(i - 1);
      end
   end

   // Count of the candidate that will be selected after this edge
   always_comb begin
      sel_cnt = '0;
      for (int unsigned i = 0; i < NUM_CAND; i++) begin
         if (sel_d == IDX_W'(i)) sel_cnt = votes[i*CNT_W +: CNT_W];
      end
   end

   // Fit the count onto the LED bus: saturate when the count is wider
   if (CNT_W > LED_W) begin : g_sat
      assign disp = (|sel_cnt[CNT_W-1:LED_W]) ? '1 : sel_cnt[LED_W-1:0];
   end else begin : g_ext
      assign disp = LED_W'(sel_cnt);
   end

   // Mode FSM, flash counter and selection latch
   always_comb begin
      state_d   = state_q;
      cnt_d     = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
      sel_d     = sel_q;
      sel_vld_d = sel_vld_q;
      case (state_q)
         VOTE_IDLE, VOTE_FLASH: begin
            if (mode) begin
               state_d = RESULT_BLANK;
               cnt_d   = '0;
            end else begin
               if (valid_vote_casted) cnt_d = CW'(FLASH_CYCLES);
               state_d = (cnt_d != '0) ? VOTE_FLASH : VOTE_IDLE;
            end
         end
         RESULT_BLANK, RESULT_SHOW: begin
            cnt_d = '0;
            if (!mode) begin
               state_d   = VOTE_IDLE;
               sel_d     = '0;
               sel_vld_d = 1'b0;
            end else if (btn_any) begin
               state_d   = RESULT_SHOW;
               sel_d     = btn_idx;
               sel_vld_d = 1'b1;
            end
         end
         default: state_d = VOTE_IDLE;
      endcase
   end

   // Output drive derived from next-state values so it registers with no extra lag
   always_comb begin
      leds_d  = '0;
      flash_d = (cnt_d != '0);
      if (state_d == RESULT_SHOW && sel_vld_d) leds_d = disp;
      else if (cnt_d != '0)                    leds_d = '1;
   end

   // Winner search: lowest index of the maximum, plus tie and all-zero detection
   always_comb begin
      max_v    = votes[CNT_W-1:0];
      winner_d = '0;
      n_max    = 0;
      for (int unsigned i = 1; i < NUM_CAND; i++) begin
         if (votes[i*CNT_W +: CNT_W] > max_v) begin
            max_v    = votes[i*CNT_W +: CNT_W];
            winner_d = IDX_W'(i);
         end
      end
      for (int unsigned i = 0; i < NUM_CAND; i++) begin
         if (votes[i*CNT_W +: CNT_W] == max_v) n_max = n_max + 1;
      end
      tie_d = (n_max >= 2);
      nov_d = (max_v == '0);
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= VOTE_IDLE;
         cnt_q     <= '0;
         sel_q     <= '0;
         sel_vld_q <= 1'b0;
         leds_q    <= '0;
         flash_q   <= 1'b0;
         winner_q  <= '0;
         tie_q     <= 1'b0;
         nov_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sel_q     <= sel_d;
         sel_vld_q <= sel_vld_d;
         leds_q    <= leds_d;
         flash_q   <= flash_d;
         winner_q  <= winner_d;
         tie_q     <= tie_d;
         nov_q     <= nov_d;
      end
   end

   assign leds         = leds_q;
   assign flash_active = flash_q;
   assign winner_idx   = winner_q;
   assign tie          = tie_q;
   assign no_votes     = nov_q;

endmodule

// File: tb/tb_vote_display_ctrl.sv
// Bench for vote_display_ctrl: default instance (8-bit counts) plus a
// CNT_W=10 instance for the saturating display path.
module tb_vote_display_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        mode, valid;
   logic [31:0] votes;
   logic [3:0]  btn;
   logic [7:0]  leds;
   logic        flash;
   logic [1:0]  widx;
   logic        tie, nov;

   logic        mode2, valid2;
   logic [39:0] votes2;
   logic [3:0]  btn2;
   logic [7:0]  leds2;
   logic        flash2;
   logic [1:0]  widx2;
   logic        tie2, nov2;

   int checks = 0;
   int errors = 0;

   typedef struct {string name; logic [7:0] leds; logic flash;} exp_t;
   typedef struct {string name; logic [1:0] idx; logic tie; logic nov;} wexp_t;
   exp_t  sb[$];
   exp_t  sb2[$];
   wexp_t wsb[$];

   vote_display_ctrl #(.NUM_CAND(4), .CNT_W(8), .LED_W(8), .FLASH_CYCLES(10)) u_dut (
      .clk(clk), .reset(reset), .mode(mode), .valid_vote_casted(valid),
      .votes(votes), .button_press(btn), .leds(leds), .flash_active(flash),
      .winner_idx(widx), .tie(tie), .no_votes(nov));

   vote_display_ctrl #(.NUM_CAND(4), .CNT_W(10), .LED_W(8), .FLASH_CYCLES(10)) u_wide (
      .clk(clk), .reset(reset), .mode(mode2), .valid_vote_casted(valid2),
      .votes(votes2), .button_press(btn2), .leds(leds2), .flash_active(flash2),
      .winner_idx(widx2), .tie(tie2), .no_votes(nov2));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(string n, logic [7:0] l, logic f);
      exp_t e;
      e.name = n; e.leds = l; e.flash = f;
      sb.push_back(e);
   endtask

   task automatic wpush(string n, logic [1:0] i, logic t, logic nv);
      wexp_t w;
      w.name = n; w.idx = i; w.tie = t; w.nov = nv;
      wsb.push_back(w);
   endtask

   task automatic test_reset();
      exp_t e;
      wexp_t w;
      reset = 1'b1; mode = 0; valid = 0; votes = '0; btn = '0;
      mode2 = 0; valid2 = 0; votes2 = '0; btn2 = '0;
      #1 reset = 1'b0;
      #2;
      checks++; if (leds !== 8'h00)  begin errors++; $display("FAIL rst_leds: got %h want 00", leds); end
      checks++; if (flash !== 1'b0)  begin errors++; $display("FAIL rst_flash: got %b want 0", flash); end
      checks++; if (widx !== 2'd0)   begin errors++; $display("FAIL rst_widx: got %0d want 0", widx); end
      checks++; if (tie !== 1'b0)    begin errors++; $display("FAIL rst_tie: got %b want 0", tie); end
      checks++; if (nov !== 1'b1)    begin errors++; $display("FAIL rst_nov: got %b want 1", nov); end
      checks++; if (leds2 !== 8'h00) begin errors++; $display("FAIL rst_leds2: got %h want 00", leds2); end
      @(negedge clk) reset = 1'b1;
      push("post_rst", 8'h00, 1'b0);
      wpush("post_rst_win", 2'd0, 1'b1, 1'b1);
      step();
      e = sb.pop_front();
      checks++; if (leds !== e.leds)   begin errors++; $display("FAIL %s leds: got %h want %h", e.name, leds, e.leds); end
      checks++; if (flash !== e.flash) begin errors++; $display("FAIL %s flash: got %b want %b", e.name, flash, e.flash); end
      w = wsb.pop_front();
      checks++; if (widx !== w.idx) begin errors++; $display("FAIL %s idx: got %0d want %0d", w.name, widx, w.idx); end
      checks++; if (tie !== w.tie)  begin errors++; $display("FAIL %s tie: got %b want %b", w.name, tie, w.tie); end
      checks++; if (nov !== w.nov)  begin errors++; $display("FAIL %s nov: got %b want %b", w.name, nov, w.nov); end
   endtask

   // Single pulse (edge 0) then a pulse at 0 and 5: flash lasts 10 / 15 edges
   task automatic test_flash();
      exp_t e;
      for (int r = 0; r < 2; r++) begin
         int len = (r == 0) ? 10 : 15;
         for (int c = 0; c < len + 2; c++) begin
            valid = (c == 0) || (r == 1 && c == 5);
            push((r == 0) ? "flash_single" : "flash_retrig",
                 (c < len) ? 8'hFF : 8'h00, c < len);
            step();
            valid = 1'b0;
            e = sb.pop_front();
            checks++; if (leds !== e.leds)   begin errors++; $display("FAIL %s[%0d] leds: got %h want %h", e.name, c, leds, e.leds); end
            checks++; if (flash !== e.flash) begin errors++; $display("FAIL %s[%0d] flash: got %b want %b", e.name, c, flash, e.flash); end
         end
      end
   endtask

   task automatic test_abort();
      exp_t e;
      valid = 1'b1; step(); valid = 1'b0;
      step(); step();
      mode = 1'b1;
      for (int c = 0; c < 5; c++) begin
         push("abort", 8'h00, 1'b0);
         step();
         valid = 1'b1;
         e = sb.pop_front();
         checks++; if (leds !== e.leds)   begin errors++; $display("FAIL %s[%0d] leds: got %h want %h", e.name, c, leds, e.leds); end
         checks++; if (flash !== e.flash) begin errors++; $display("FAIL %s[%0d] flash: got %b want %b", e.name, c, flash, e.flash); end
      end
      valid = 1'b0;
   endtask

   // Selection latch, live tracking and winner logic in result mode
   task automatic test_result();
      exp_t e;
      wexp_t w;
      logic [31:0] v_tab [8];
      logic [3:0]  b_tab [8];
      logic [7:0]  l_tab [8];
      logic [1:0]  i_tab [8];
      logic        t_tab [8];
      // cand3..cand0
      v_tab = '{32'h07_03_09_03, 32'h07_03_09_03, 32'h07_03_09_03, 32'h07_03_04_03,
                32'h07_03_09_03, 32'h09_03_09_03, 32'h09_03_09_09, 32'h09_03_09_09};
      b_tab = '{4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
      l_tab = '{8'd9, 8'd9, 8'd9, 8'd4, 8'd9, 8'd9, 8'd9, 8'd9};
      i_tab = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd1, 2'd1, 2'd0, 2'd0};
      t_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      l_tab[7] = 8'd9;
      for (int c = 0; c < 8; c++) begin
         votes = v_tab[c];
         btn   = b_tab[c];
         push("result", l_tab[c], 1'b0);
         wpush("winner", i_tab[c], t_tab[c], 1'b0);
         step();
         e = sb.pop_front();
         checks++; if (leds !== e.leds)   begin errors++; $display("FAIL %s[%0d] leds: got %0d want %0d", e.name, c, leds, e.leds); end
         checks++; if (flash !== e.flash) begin errors++; $display("FAIL %s[%0d] flash: got %b want %b", e.name, c, flash, e.flash); end
         w = wsb.pop_front();
         checks++; if (widx !== w.idx) begin errors++; $display("FAIL %s[%0d] idx: got %0d want %0d", w.name, c, widx, w.idx); end
         checks++; if (tie !== w.tie)  begin errors++; $display("FAIL %s[%0d] tie: got %b want %b", w.name, c, tie, w.tie); end
         checks++; if (nov !== w.nov)  begin errors++; $display("FAIL %s[%0d] nov: got %b want %b", w.name, c, nov, w.nov); end
      end
      btn = '0;
   endtask

   // Mode change in the same cycle as a press: the press is ignored
   task automatic test_mode_priority();
      exp_t e;
      logic       m_tab [4];
      logic [3:0] b_tab [4];
      logic [7:0] l_tab [4];
      m_tab = '{1'b0, 1'b1, 1'b1, 1'b1};
      b_tab = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};
      l_tab = '{8'd0, 8'd0, 8'd9, 8'd9};
      for (int c = 0; c < 4; c++) begin
         mode = m_tab[c];
         btn  = b_tab[c];
         push("mode_prio", l_tab[c], 1'b0);
         step();
         e = sb.pop_front();
         checks++; if (leds !== e.leds)   begin errors++; $display("FAIL %s[%0d] leds: got %0d want %0d", e.name, c, leds, e.leds); end
         checks++; if (flash !== e.flash) begin errors++; $display("FAIL %s[%0d] flash: got %b want %b", e.name, c, flash, e.flash); end
      end
   endtask

   // Saturation on the wide instance, then reset mid-flash / mid-display
   task automatic test_saturate_reset();
      exp_t e;
      logic [3:0] b_tab [5];
      logic [7:0] l_tab [5];
      b_tab = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      l_tab = '{8'h00, 8'hFF, 8'hC8, 8'hFF, 8'hFF};
      votes2 = {10'd256, 10'd255, 10'd200, 10'd300};
      mode2  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         btn2 = b_tab[c];
         e.name = "saturate"; e.leds = l_tab[c]; e.flash = 1'b0;
         sb2.push_back(e);
         step();
         e = sb2.pop_front();
         checks++; if (leds2 !== e.leds) begin errors++; $display("FAIL %s[%0d] leds2: got %h want %h", e.name, c, leds2, e.leds); end
      end
      checks++; if (widx2 !== 2'd0 || tie2 !== 1'b0) begin errors++; $display("FAIL wide_winner: got idx %0d tie %b want idx 0 tie 0", widx2, tie2); end
      btn2 = 4'b0010;
      mode = 1'b0; btn = '0;
      step();
      valid = 1'b1;
      step();
      valid = 1'b0;
      checks++; if (flash !== 1'b1 || leds2 !== 8'hC8) begin errors++; $display("FAIL pre_rst: got flash %b leds2 %h want flash 1 leds2 c8", flash, leds2); end
      #2 reset = 1'b0;
      #1;
      checks++; if (leds !== 8'h00)  begin errors++; $display("FAIL mid_rst_leds: got %h want 00", leds); end
      checks++; if (flash !== 1'b0)  begin errors++; $display("FAIL mid_rst_flash: got %b want 0", flash); end
      checks++; if (leds2 !== 8'h00) begin errors++; $display("FAIL mid_rst_leds2: got %h want 00", leds2); end
      checks++; if (nov2 !== 1'b1 || tie2 !== 1'b0) begin errors++; $display("FAIL mid_rst_win2: got nov %b tie %b want nov 1 tie 0", nov2, tie2); end
      @(negedge clk) reset = 1'b1;
   endtask

   initial begin
      test_reset();
      test_flash();
      test_abort();
      test_result();
      test_mode_priority();
      test_saturate_reset();
      checks++; if (sb.size() != 0 || sb2.size() != 0 || wsb.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size() + sb2.size() + wsb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule
